// File: rtl/multicycle_controller_if.sv
// Datapath-facing bundle of the multicycle controller.
//
// Purpose: carries the instruction word and ALU zero flag from the datapath
// into the controller, and every control strobe from the controller back out.
//
// Signals:
//   instruction                  instruction word from instruction memory
//   zero                         ALU zero flag
//   mem_ready                    data-memory done (present only with CTRL_MEM_WAIT_EN)
//   RegisterWriteDataEnable      register file write strobe
//   RegisterWriteDataDestination 1 = write ALU result, 0 = write memory data
//   LoadPcEnable                 PC update strobe
//   SelectBranchPc               PC source = branch target
//   SelectJumpPc                 PC source = jump target
//   MemoryWriteDataEnable        data-memory write strobe
//   SelectImm                    ALU operand 2 = sign-extended immediate
//
// Modports: master = controller side, slave = datapath side.
// Optional macro: CTRL_MEM_WAIT_EN adds the mem_ready handshake signal.

interface multicycle_controller_if #(
   parameter int INSTR_W = 16
);

   logic [INSTR_W-1:0] instruction;
   logic               zero;
`ifdef CTRL_MEM_WAIT_EN
   logic               mem_ready;
`endif
   logic               RegisterWriteDataEnable;
   logic               RegisterWriteDataDestination;
   logic               LoadPcEnable;
   logic               SelectBranchPc;
   logic               SelectJumpPc;
   logic               MemoryWriteDataEnable;
   logic               SelectImm;

   modport master (
      input  instruction,
      input  zero,
`ifdef CTRL_MEM_WAIT_EN
      input  mem_ready,
`endif
      output RegisterWriteDataEnable,
      output RegisterWriteDataDestination,
      output LoadPcEnable,
      output SelectBranchPc,
      output SelectJumpPc,
      output MemoryWriteDataEnable,
      output SelectImm
   );

   modport slave (
      output instruction,
      output zero,
`ifdef CTRL_MEM_WAIT_EN
      output mem_ready,
`endif
      input  RegisterWriteDataEnable,
      input  RegisterWriteDataDestination,
      input  LoadPcEnable,
      input  SelectBranchPc,
      input  SelectJumpPc,
      input  MemoryWriteDataEnable,
      input  SelectImm
   );

endinterface

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the 16-bit datapath.
//
// Purpose: sequences fetch/decode/execute/memory/writeback for one instruction
// at a time, drives every datapath control strobe from the current state and
// the latched opcode, and counts retired instructions for debug.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   bus        datapath bundle (multicycle_controller_if.master)
//   state_out  current state encoding (debug)
//   halted     sticky, set once a HALT instruction is decoded
//   illegal_op high during DECODE of an unknown opcode
//   retired    instructions retired since reset (wraps silently)
//
// Optional macro: CTRL_MEM_WAIT_EN makes the MEM state wait for mem_ready;
// without it MEM always lasts exactly one cycle.

module multicycle_controller #(
   parameter int INSTR_W   = 16,
   parameter int RET_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_controller_if.master bus,
   output logic [2:0]           state_out,
   output logic                 halted,
   output logic                 illegal_op,
   output logic [RET_CNT_W-1:0] retired
);

   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] MEM    = 3'd3;
   localparam logic [2:0] WB     = 3'd4;
   localparam logic [2:0] HALT   = 3'd5;

   localparam logic [3:0] OP_ALU_R = 4'h0;
   localparam logic [3:0] OP_ALU_I = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_STORE = 4'h3;
   localparam logic [3:0] OP_JUMP  = 4'h4;
   localparam logic [3:0] OP_BEQZ  = 4'h5;
   localparam logic [3:0] OP_HALT  = 4'hF;

   logic [2:0]           state;
   logic [2:0]           state_next;
   logic [3:0]           op_q;
   logic                 halted_q;
   logic [RET_CNT_W-1:0] retired_q;
   logic                 mem_done;
   logic                 op_legal;
   logic                 retire;

   // Only the opcode field is held; the remaining instruction bits feed the
   // datapath directly from its own instruction register.
`ifdef CTRL_MEM_WAIT_EN
   assign mem_done = bus.mem_ready;
`else
   assign mem_done = 1'b1;
`endif

   // Opcodes 0..5 execute; F halts; everything else is rejected in DECODE.
   assign op_legal = (op_q <= OP_BEQZ);

   // The final cycle of each executing instruction: WB for ALU/LOAD, the
   // completing MEM cycle for STORE, EXEC for JUMP/BEQZ.
   assign retire = (state == WB) ||
                   ((state == MEM) && (op_q == OP_STORE) && mem_done) ||
                   ((state == EXEC) && ((op_q == OP_JUMP) || (op_q == OP_BEQZ)));

   always_comb begin
      state_next = FETCH;
      case (state)
         FETCH:  state_next = DECODE;
         DECODE: begin
            if (op_legal)
               state_next = EXEC;
            else if (op_q == OP_HALT)
               state_next = HALT;
            else
               state_next = FETCH;
         end
         EXEC: begin
            case (op_q)
               OP_ALU_R, OP_ALU_I: state_next = WB;
               OP_LOAD, OP_STORE:  state_next = MEM;
               default:            state_next = FETCH;
            endcase
         end
         MEM: begin
            if (!mem_done)
               state_next = MEM;
            else if (op_q == OP_LOAD)
               state_next = WB;
            else
               state_next = FETCH;
         end
         WB:      state_next = FETCH;
         HALT:    state_next = HALT;
         default: state_next = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= FETCH;
         op_q      <= 4'h0;
         halted_q  <= 1'b0;
         retired_q <= '0;
      end else begin
         state <= state_next;
         if (state == FETCH)
            op_q <= bus.instruction[INSTR_W-1 -: 4];
         if ((state == DECODE) && (op_q == OP_HALT))
            halted_q <= 1'b1;
         if (retire)
            retired_q <= retired_q + RET_CNT_W'(1);
      end
   end

   // Strobes follow state and latched opcode only, except SelectBranchPc
   // (follows zero in EXEC of BEQZ) and, with the memory wait enabled, the
   // STORE PC load, which fires only on the cycle memory completes.
   always_comb begin
      bus.RegisterWriteDataEnable      = 1'b0;
      bus.RegisterWriteDataDestination = 1'b0;
      bus.LoadPcEnable                 = 1'b0;
      bus.SelectBranchPc               = 1'b0;
      bus.SelectJumpPc                 = 1'b0;
      bus.MemoryWriteDataEnable        = 1'b0;
      bus.SelectImm                    = 1'b0;
      illegal_op                       = 1'b0;
      case (state)
         DECODE: illegal_op = !op_legal && (op_q != OP_HALT);
         EXEC: begin
            case (op_q)
               OP_ALU_I, OP_LOAD, OP_STORE: bus.SelectImm = 1'b1;
               OP_JUMP: begin
                  bus.LoadPcEnable = 1'b1;
                  bus.SelectJumpPc = 1'b1;
               end
               OP_BEQZ: begin
                  bus.LoadPcEnable   = 1'b1;
                  bus.SelectBranchPc = bus.zero;
               end
               default: ;
            endcase
         end
         MEM: begin
            if (op_q == OP_STORE) begin
               bus.MemoryWriteDataEnable = 1'b1;
               bus.LoadPcEnable          = mem_done;
            end
         end
         WB: begin
            bus.RegisterWriteDataEnable      = 1'b1;
            bus.RegisterWriteDataDestination = (op_q != OP_LOAD);
            bus.LoadPcEnable                 = 1'b1;
            bus.SelectImm                    = (op_q == OP_ALU_I);
         end
         default: ;
      endcase
   end

   assign state_out = state;
   assign halted    = halted_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller.
//
// Purpose: drives directed instruction sequences and compares every cycle of
// the controller's outputs against a per-instruction trace model built from
// the opcode rules, plus literal spot checks of retired/state/halted.
// The retired counter is built 4 bits wide here so that wraparound is reached.
// Optional macro: CTRL_MEM_WAIT_EN enables the memory-wait scenario.

module tb_multicycle_controller;

   localparam int RW = 4;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   typedef struct packed {
      logic [2:0]    st;
      logic          wr;
      logic          dest;
      logic          pc;
      logic          br;
      logic          jmp;
      logic          memw;
      logic          imm;
      logic          hlt;
      logic          ill;
      logic [RW-1:0] ret;
   } rec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [2:0]    state_out;
   logic          halted;
   logic          illegal_op;
   logic [RW-1:0] retired;

   int n_checks = 0;
   int n_pass   = 0;

   rec_t          exp_q[$];
   rec_t          trace[$];
   logic [RW-1:0] model_ret    = '0;
   logic          model_halted = 1'b0;

   always #5 clk = ~clk;

   multicycle_controller_if #(.INSTR_W(16)) bus_if();

   multicycle_controller #(
      .INSTR_W   (16),
      .RET_CNT_W (RW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus_if.master),
      .state_out  (state_out),
      .halted     (halted),
      .illegal_op (illegal_op),
      .retired    (retired)
   );

   // One comparison: counts it and reports any disagreement.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req)
         n_pass++;
      else
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   function automatic rec_t blank(input logic [2:0] st);
      rec_t r;
      r     = '0;
      r.st  = st;
      r.hlt = model_halted;
      r.ret = model_ret;
      return r;
   endfunction

   // Model: the cycle-by-cycle output trace one instruction must produce.
   task automatic buildTrace(input logic [15:0] instr, input logic zv, input int waits);
      logic [3:0] op;
      rec_t       r;
      op = instr[15:12];
      trace.delete();
      trace.push_back(blank(S_FETCH));
      r     = blank(S_DECODE);
      r.ill = (op >= 4'h6) && (op <= 4'hE);
      trace.push_back(r);
      case (op)
         4'h0, 4'h1: begin
            r = blank(S_EXEC); r.imm = (op == 4'h1); trace.push_back(r);
            r = blank(S_WB);   r.imm = (op == 4'h1);
            r.wr = 1'b1; r.dest = 1'b1; r.pc = 1'b1; trace.push_back(r);
            model_ret++;
         end
         4'h2: begin
            r = blank(S_EXEC); r.imm = 1'b1; trace.push_back(r);
            for (int w = 0; w <= waits; w++) trace.push_back(blank(S_MEM));
            r = blank(S_WB); r.wr = 1'b1; r.pc = 1'b1; trace.push_back(r);
            model_ret++;
         end
         4'h3: begin
            r = blank(S_EXEC); r.imm = 1'b1; trace.push_back(r);
            for (int w = 0; w < waits; w++) begin
               r = blank(S_MEM); r.memw = 1'b1; trace.push_back(r);
            end
            r = blank(S_MEM); r.memw = 1'b1; r.pc = 1'b1; trace.push_back(r);
            model_ret++;
         end
         4'h4: begin
            r = blank(S_EXEC); r.pc = 1'b1; r.jmp = 1'b1; trace.push_back(r);
            model_ret++;
         end
         4'h5: begin
            r = blank(S_EXEC); r.pc = 1'b1; r.br = zv; trace.push_back(r);
            model_ret++;
         end
         4'hF: begin
            model_halted = 1'b1;
            for (int k = 0; k < 20; k++) trace.push_back(blank(S_HALT));
         end
         default: ;
      endcase
   endtask

   // Called at the start of a FETCH cycle; plays one instruction through,
   // scrambling instruction/zero in cycles where they must be ignored.
   task automatic applyStimulus(input logic [15:0] instr, input logic zv, input int waits);
      int mem_idx;
      mem_idx = 0;
      buildTrace(instr, zv, waits);
      foreach (trace[i]) exp_q.push_back(trace[i]);
      foreach (trace[i]) begin
         bus_if.instruction = (i == 0) ? instr : 16'($urandom);
         bus_if.zero        = (trace[i].st == S_EXEC) ? zv : 1'($urandom);
`ifdef CTRL_MEM_WAIT_EN
         if (trace[i].st == S_MEM) begin
            bus_if.mem_ready = (mem_idx == waits);
            mem_idx++;
         end else begin
            bus_if.mem_ready = 1'($urandom);
         end
`endif
         @(posedge clk);
         #1;
      end
   endtask

   task automatic resetPulse();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst          = 1'b1;
      model_ret    = '0;
      model_halted = 1'b0;
   endtask

   // Per-cycle comparison against the model trace, sampled mid-cycle.
   always @(negedge clk) begin
      rec_t e;
      rec_t a;
      if (exp_q.size() > 0) begin
         e      = exp_q.pop_front();
         a.st   = state_out;
         a.wr   = bus_if.RegisterWriteDataEnable;
         a.dest = bus_if.RegisterWriteDataDestination;
         a.pc   = bus_if.LoadPcEnable;
         a.br   = bus_if.SelectBranchPc;
         a.jmp  = bus_if.SelectJumpPc;
         a.memw = bus_if.MemoryWriteDataEnable;
         a.imm  = bus_if.SelectImm;
         a.hlt  = halted;
         a.ill  = illegal_op;
         a.ret  = retired;
         checkOutput($sformatf("cycle_state%0d", e.st), 32'(a), 32'(e));
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [6:0] strobes;
      bus_if.instruction = 16'($urandom);
      bus_if.zero        = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
      bus_if.mem_ready   = 1'b0;
`endif
      // T1: reset held two cycles with a random instruction present
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      strobes = {bus_if.RegisterWriteDataEnable, bus_if.RegisterWriteDataDestination,
                 bus_if.LoadPcEnable, bus_if.SelectBranchPc, bus_if.SelectJumpPc,
                 bus_if.MemoryWriteDataEnable, bus_if.SelectImm};
      checkOutput("t1_state", state_out, 3'd0);
      checkOutput("t1_strobes", strobes, 7'd0);
      checkOutput("t1_retired", retired, 4'd0);
      checkOutput("t1_halted", halted, 1'b0);
      rst = 1'b1;

      // T2: ALU-I
      applyStimulus(16'h1205, 1'b0, 0);
      checkOutput("t2_retired", retired, 4'd1);
      checkOutput("t2_state", state_out, 3'd0);

      // T3: LOAD then STORE
      applyStimulus(16'h2104, 1'b0, 0);
      applyStimulus(16'h3104, 1'b1, 0);
      checkOutput("t3_retired", retired, 4'd3);

      // T4: BEQZ taken then not taken, plus an ALU-R
      applyStimulus(16'h5010, 1'b1, 0);
      applyStimulus(16'h5010, 1'b0, 0);
      applyStimulus(16'h0123, 1'b1, 0);
      checkOutput("t4_retired", retired, 4'd6);

      // Sixteen jumps wrap the 4-bit retired counter back to the same value
      for (int j = 0; j < 16; j++)
         applyStimulus(16'h4000 | 16'($urandom_range(0, 16'h0FFF)), 1'($urandom), 0);
      checkOutput("wrap_retired", retired, 4'd6);

      // T5: illegal opcode then HALT
      applyStimulus(16'h7000, 1'b0, 0);
      checkOutput("t5_illegal_retired", retired, 4'd6);
      applyStimulus(16'hE0FF, 1'b0, 0);
      applyStimulus(16'hF000, 1'b0, 0);
      checkOutput("t5_halted", halted, 1'b1);
      checkOutput("t5_state", state_out, 3'd5);

      // Reset clears halt
      resetPulse();
      checkOutput("rst_halted", halted, 1'b0);
      checkOutput("rst_state", state_out, 3'd0);

      // Reset aborts an ALU instruction in WB: no strobes, no retire
      bus_if.instruction = 16'h0123;
      repeat (3) begin @(posedge clk); #1; end
      checkOutput("abort_wb_state", state_out, 3'd4);
      checkOutput("abort_wb_regwrite", bus_if.RegisterWriteDataEnable, 1'b1);
      resetPulse();
      checkOutput("abort_wb_after_regwrite", bus_if.RegisterWriteDataEnable, 1'b0);
      checkOutput("abort_wb_after_pc", bus_if.LoadPcEnable, 1'b0);
      checkOutput("abort_wb_after_retired", retired, 4'd0);

      // Reset aborts a STORE in MEM
      bus_if.instruction = 16'h3104;
`ifdef CTRL_MEM_WAIT_EN
      bus_if.mem_ready   = 1'b0;
`endif
      repeat (3) begin @(posedge clk); #1; end
      checkOutput("abort_mem_state", state_out, 3'd3);
      checkOutput("abort_mem_memwrite", bus_if.MemoryWriteDataEnable, 1'b1);
      resetPulse();
      checkOutput("abort_mem_after_memwrite", bus_if.MemoryWriteDataEnable, 1'b0);
      checkOutput("abort_mem_after_state", state_out, 3'd0);

      // Normal operation resumes after the abort
      applyStimulus(16'h0456, 1'b0, 0);
      checkOutput("recover_retired", retired, 4'd1);

`ifdef CTRL_MEM_WAIT_EN
      // T6: STORE with memory stalling three cycles, then a stalled LOAD
      applyStimulus(16'h3104, 1'b0, 3);
      checkOutput("t6_retired", retired, 4'd2);
      applyStimulus(16'h2104, 1'b0, 2);
      checkOutput("t6_load_retired", retired, 4'd3);
`endif

      @(posedge clk);
      #1;
      checkOutput("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
